// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int MUL_LAT_DEF = 1;
    localparam int DIV_LAT_DEF = 33;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_muldiv_seq.sv
// rtl/hazard_ctrl_muldiv_seq.sv - multi-cycle M-extension occupancy FSM and down-counter
import hazard_pkg::*;

module muldiv_seq #(
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [CNT_W:0] lat,
    input  logic           abort,
    output logic           stall,
    output logic           busy,
    output logic           done
);

    localparam logic [CNT_W:0]   LAT_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   LAT_TWO = (CNT_W + 1)'(2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W:0]   lat_m2;

    assign lat_m2 = lat - LAT_TWO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The first EX cycle is spent in IDLE, so BUSY covers the remaining L-1 cycles.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (lat == LAT_ONE) begin
                        done = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        cnt_n   = lat_m2[CNT_W-1:0];
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (abort) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt != '0) begin
                    stall = 1'b1;
                    cnt_n = cnt - CNT_ONE;
                end else begin
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use, redirect and muldiv stall/flush control for the 5-stage core
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
import hazard_pkg::*;

module hazard_ctrl #(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        ex_mul_valid,
    input  logic        ex_div_valid,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_mem_bubble,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_md_stalls,
    output logic [31:0] perf_flushes
);

    localparam logic [CNT_W:0] MUL_L = (CNT_W + 1)'(MUL_LAT);
    localparam logic [CNT_W:0] DIV_L = (CNT_W + 1)'(DIV_LAT);

    logic           lu_raw;
    logic           lu_eff;
    logic           md_start;
    logic [CNT_W:0] md_lat;
    logic           md_stall;
    logic           md_busy;
    logic           md_done;

    assign lu_raw = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

    // A redirect squashes the dependent ID instruction, and a busy EX cannot hold a load.
    assign lu_eff = lu_raw && !ex_redirect && !md_busy;

    // Simultaneous MUL and DIV valid resolves to the longer DIV latency.
    assign md_start = ex_mul_valid || ex_div_valid;
    assign md_lat   = ex_div_valid ? DIV_L : MUL_L;

    muldiv_seq #(
        .CNT_W (CNT_W)
    ) u_muldiv_seq (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .lat   (md_lat),
        .abort (ex_redirect),
        .stall (md_stall),
        .busy  (md_busy),
        .done  (md_done)
    );

    // Outputs are held low while reset is asserted even if the inputs are active.
    assign pc_stall      = rst_n && (lu_eff || md_stall);
    assign if_id_stall   = rst_n && (lu_eff || md_stall);
    assign if_id_flush   = rst_n && ex_redirect;
    assign id_ex_stall   = rst_n && md_stall;
    assign id_ex_flush   = rst_n && (ex_redirect || lu_eff);
    assign ex_mem_bubble = rst_n && md_stall;
    assign muldiv_busy   = rst_n && md_busy;
    assign muldiv_done   = rst_n && md_done;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt;
    logic [31:0] md_cnt;
    logic [31:0] fl_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            md_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            if (lu_eff) begin
                lu_cnt <= sat_inc(lu_cnt);
            end
            if (md_stall) begin
                md_cnt <= sat_inc(md_cnt);
            end
            if (ex_redirect) begin
                fl_cnt <= sat_inc(fl_cnt);
            end
        end
    end

    assign perf_lu_stalls = lu_cnt;
    assign perf_md_stalls = md_cnt;
    assign perf_flushes   = fl_cnt;
`else
    assign perf_lu_stalls = '0;
    assign perf_md_stalls = '0;
    assign perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table and sequence checks of hazard_ctrl against two latency configurations
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rstn;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mul;
        logic       div;
        logic       mul3;
        logic       div3;
        logic [7:0] exp;
        logic [7:0] exp3;
        logic       chk3;
    } vec_t;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble, busy, done}
    localparam logic [7:0] NONE = 8'h00;
    localparam logic [7:0] LU   = 8'hC8;
    localparam logic [7:0] FL   = 8'h28;
    localparam logic [7:0] STL  = 8'hD4;
    localparam logic [7:0] BSTL = 8'hD6;
    localparam logic [7:0] BFIN = 8'h03;
    localparam logic [7:0] DONE = 8'h01;
    localparam logic [7:0] BFL  = 8'h2A;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic ex_mul_valid = 1'b0, ex_div_valid = 1'b0, mul3 = 1'b0, div3 = 1'b0;

    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_bubble;
    logic muldiv_busy, muldiv_done;
    logic [31:0] perf_lu_stalls, perf_md_stalls, perf_flushes;
    logic o3_pc_stall, o3_if_id_stall, o3_if_id_flush, o3_id_ex_stall, o3_id_ex_flush;
    logic o3_ex_mem_bubble, o3_busy, o3_done;
    logic [31:0] o3_perf_lu, o3_perf_md, o3_perf_fl;

    int n_vec = 0;
    int n_bad = 0;
    int vid = 0;
    logic [16:0] exp_q[$];
    int id_q[$];

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_mul_valid(ex_mul_valid), .ex_div_valid(ex_div_valid),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
        .perf_lu_stalls(perf_lu_stalls), .perf_md_stalls(perf_md_stalls),
        .perf_flushes(perf_flushes)
    );

    hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(3), .CNT_W(6)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .ex_mul_valid(mul3), .ex_div_valid(div3),
        .pc_stall(o3_pc_stall), .if_id_stall(o3_if_id_stall), .if_id_flush(o3_if_id_flush),
        .id_ex_stall(o3_id_ex_stall), .id_ex_flush(o3_id_ex_flush),
        .ex_mem_bubble(o3_ex_mem_bubble), .muldiv_busy(o3_busy), .muldiv_done(o3_done),
        .perf_lu_stalls(o3_perf_lu), .perf_md_stalls(o3_perf_md), .perf_flushes(o3_perf_fl)
    );

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        v.rstn = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic [4:0] rd, input logic mr,
                                input logic redir, input logic div, input logic [7:0] exp);
        vec_t v;
        v = idle();
        v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2; v.rd = rd;
        v.mr = mr; v.redir = redir; v.div = div; v.exp = exp;
        return v;
    endfunction

    task automatic check_out();
        logic [16:0] e;
        int          id;
        logic [7:0]  got, got3;
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        got  = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                ex_mem_bubble, muldiv_busy, muldiv_done};
        got3 = {o3_pc_stall, o3_if_id_stall, o3_if_id_flush, o3_id_ex_stall, o3_id_ex_flush,
                o3_ex_mem_bubble, o3_busy, o3_done};
        n_vec++;
        if (got !== e[7:0]) begin
            n_bad++;
            $display("FAIL vec%0d ctrl got %b want %b", id, got, e[7:0]);
        end
        if (e[16]) begin
            n_vec++;
            if (got3 !== e[15:8]) begin
                n_bad++;
                $display("FAIL vec%0d ctrl_lat3 got %b want %b", id, got3, e[15:8]);
            end
        end
    endtask

    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        rst_n = v.rstn; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.use1;
        id_use_rs2 = v.use2; ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.redir;
        ex_mul_valid = v.mul; ex_div_valid = v.div; mul3 = v.mul3; div3 = v.div3;
        exp_q.push_back({v.chk3, v.exp3, v.exp});
        id_q.push_back(vid);
        vid++;
        @(negedge clk);
        check_out();
    endtask

    task automatic check_perf(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic [31:0] want_lu, want_md, want_fl;

        tbl[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, NONE);
        tbl[1] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, LU);
        tbl[2] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, NONE);
        tbl[3] = mk(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, LU);
        tbl[4] = mk(5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, NONE);
        tbl[5] = mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, NONE);
        tbl[6] = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, FL);
        tbl[7] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, FL);
        tbl[8] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, FL);
        tbl[9] = mk(5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, NONE);

        // Reset state with active load-use inputs and a DIV pending.
        v = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, NONE);
        v.rstn = 1'b0; v.chk3 = 1'b1; v.div3 = 1'b1; v.exp3 = NONE;
        step(v);
        check_perf("reset_perf_lu", perf_lu_stalls, 32'd0);
        check_perf("reset_perf_md", perf_md_stalls, 32'd0);
        check_perf("reset_perf_fl", perf_flushes, 32'd0);

        // Counter scenario: one load-use, one DIV of 33 cycles, two redirects.
        step(tbl[1]);
        v = idle(); v.div = 1'b1; v.exp = STL; step(v);
        for (int i = 0; i < 31; i++) begin
            v.exp = BSTL; step(v);
        end
        v.exp = BFIN; step(v);
        step(idle());
        step(tbl[7]);
        step(tbl[7]);
        step(idle());
`ifdef HAZARD_PERF_CNT_EN
        want_lu = 32'd1; want_md = 32'd32; want_fl = 32'd2;
`else
        want_lu = 32'd0; want_md = 32'd0; want_fl = 32'd0;
`endif
        check_perf("perf_lu_stalls", perf_lu_stalls, want_lu);
        check_perf("perf_md_stalls", perf_md_stalls, want_md);
        check_perf("perf_flushes", perf_flushes, want_fl);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i]);
        end

        // Single-cycle MUL on the default core; 3-cycle MUL on the second.
        v = idle(); v.mul = 1'b1; v.exp = DONE; v.mul3 = 1'b1; v.chk3 = 1'b1; v.exp3 = STL;
        step(v);
        v.mul = 1'b0; v.exp = NONE; v.exp3 = BSTL; step(v);
        v.exp3 = BFIN; step(v);
        v = idle(); v.chk3 = 1'b1; v.exp3 = NONE; step(v);

        // Back-to-back 3-cycle DIVs with no dead cycle between them.
        for (int k = 0; k < 2; k++) begin
            v = idle(); v.div3 = 1'b1; v.chk3 = 1'b1;
            v.exp3 = STL; step(v);
            v.exp3 = BSTL; step(v);
            v.exp3 = BFIN; step(v);
        end
        v = idle(); v.chk3 = 1'b1; v.exp3 = NONE; step(v);

        // MUL and DIV together count as DIV; a redirect then aborts with no done.
        v = idle(); v.mul = 1'b1; v.div = 1'b1; v.exp = STL; step(v);
        v = idle(); v.div = 1'b1; v.redir = 1'b1; v.exp = BFL; step(v);
        step(idle());

        // Load-use is masked while the muldiv unit is busy.
        v = idle(); v.div = 1'b1; v.exp = STL; step(v);
        v = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, BSTL); step(v);
        v = idle(); v.div = 1'b1; v.redir = 1'b1; v.exp = BFL; step(v);
        step(idle());

        // Reset asserted in cycle 10 of a DIV, then released.
        v = idle(); v.div = 1'b1; v.exp = STL; step(v);
        for (int i = 0; i < 8; i++) begin
            v.exp = BSTL; step(v);
        end
        v.rstn = 1'b0; v.exp = NONE; step(v);
        step(idle());
        step(idle());
        check_perf("post_reset_perf_md", perf_md_stalls, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32IM core. It drives stall and flush control into the PC, IF/ID and ID/EX pipeline registers and bubbles EX/MEM. It detects load-use hazards, squashes wrong-path instructions on taken branches/jumps, and holds the ID/EX stage for multi-cycle M-extension ops.
It sits beside the decode stage and sees ID-stage register indices and EX-stage control fields.

Parameters:
MUL_LAT, 1, cycles a MUL/MULH* occupies EX (>=1)
DIV_LAT, 33, cycles a DIV/REM* occupies EX (>=1)
CNT_W, 6, width of muldiv cycle counter (must hold max(MUL_LAT,DIV_LAT)-1)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/JAL/JALR
ex_mul_valid  in  1  EX holds a MUL-class op
ex_div_valid  in  1  EX holds a DIV/REM-class op
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  zero IF/ID (NOP)
id_ex_stall  out  1  hold ID/EX contents
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_bubble  out  1  EX/MEM captures bubble (no writes)
muldiv_busy  out  1  FSM in BUSY
muldiv_done  out  1  final EX cycle of multi-cycle op
perf_lu_stalls  out  32  load-use stall cycles
perf_md_stalls  out  32  muldiv stall cycles
perf_flushes  out  32  redirect flush events

Behaviour:
- Stall/flush outputs are combinational from inputs and FSM state; only FSM, counter and perf counters are registered.
- During reset (rst_n low): FSM=IDLE, cnt=0, perf counters=0, all outputs 0.
- Load-use: lu = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). When lu is active and takes effect: pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle. x0 never hazards.
- Redirect: ex_redirect=1 -> if_id_flush=1, id_ex_flush=1, no stalls. Redirect wins over lu; lu is suppressed.
- Muldiv FSM, states IDLE/BUSY. L = MUL_LAT if ex_mul_valid, else DIV_LAT.
  - IDLE, valid op, L==1: muldiv_done=1, no stall, stay IDLE.
  - IDLE, valid op, L>1: assert stall set (pc_stall, if_id_stall, id_ex_stall, ex_mem_bubble), cnt<=L-2, go BUSY.
  - BUSY, cnt!=0: stall set, cnt<=cnt-1.
  - BUSY, cnt==0: no stall, muldiv_done=1, go IDLE. The instruction leaves EX at this edge.
  - Result: an op of latency L occupies EX for exactly L cycles.
- Back-to-back muldiv ops: the second op starts in the cycle after done, in IDLE. There is no dead cycle.
- While BUSY, lu is masked. Load-use cannot be true because EX holds the muldiv op.
- ex_redirect while BUSY, or with a muldiv valid (illegal): flush wins, FSM forced to IDLE, cnt=0, no done pulse.
- ex_mul_valid & ex_div_valid both set (illegal): treated as DIV.
- muldiv_busy = (state==BUSY).

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - perf_lu_stalls +1 per cycle that lu takes effect.
  - perf_md_stalls +1 per cycle with muldiv stall asserted.
  - perf_flushes +1 per ex_redirect cycle.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: the counter logic is not built; the three ports are tied to 0.

Decomposition:
- Shared package hazard_pkg: md_state_e enum (IDLE, BUSY); default latency constants MUL_LAT_DEF=1, DIV_LAT_DEF=33.
- One sub-module, muldiv_seq. It contains the FSM and down-counter, with inputs start/lat/abort and outputs stall/busy/done.
- hazard_ctrl instantiates muldiv_seq and adds the lu/redirect logic and perf counters.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=if_id_stall=id_ex_flush=1; repeat with ex_rd=0 -> no stall.
- Same load-use with ex_redirect=1 -> if_id_flush=id_ex_flush=1, pc_stall=0.
- ex_div_valid held, DIV_LAT=33 -> 32 consecutive stall cycles, muldiv_done=1 on cycle 33, busy=0 after.
- ex_mul_valid with MUL_LAT=1 -> done=1 the same cycle, zero stalls; with MUL_LAT=3, two DIVs back-to-back -> stalls 2, done, stalls 2, done.
- rst_n deasserted at cycle 10 of a DIV, then released -> FSM in IDLE, all outputs 0, with no done pulse.
- With HAZARD_PERF_CNT_EN: one load-use, one DIV (33), two redirects -> perf_lu=1, perf_md=32, perf_flushes=2; without the macro, all three read 0.
